// File: rtl/q_agent_pkg.sv
`default_nettype none
// ============================================================================
// q_agent_pkg : shared encodings and constants for the Q-learning agent
// Revision    : 1.0
// ============================================================================
package q_agent_pkg;

  localparam int NUM_STATES  = 32;
  localparam int NUM_ACTIONS = 4;
  localparam int Q_ENTRIES   = NUM_STATES * NUM_ACTIONS;

  localparam logic [1:0] ACT_UP    = 2'd0;
  localparam logic [1:0] ACT_DOWN  = 2'd1;
  localparam logic [1:0] ACT_LEFT  = 2'd2;
  localparam logic [1:0] ACT_RIGHT = 2'd3;

  localparam logic signed [15:0] Q_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Q_MIN = 16'sh8000;

  // x^16 + x^14 + x^13 + x^11, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_UPD  = 2'd2,
    ST_SEL  = 2'd3
  } fsm_e;

  typedef enum logic {
    MODE_STEP  = 1'b0,
    MODE_START = 1'b1
  } mode_e;

endpackage
`default_nettype wire

// File: rtl/q_lfsr16.sv
`default_nettype none
// ============================================================================
// q_lfsr16 : free-running seeded 16-bit Galois LFSR
// Revision : 1.0
// ============================================================================
module q_lfsr16
  import q_agent_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_d, lfsr_q;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/q_agent_core.sv
`default_nettype none
// ============================================================================
// q_agent_core : 32x4 Q-table with shift-based Bellman update and
//                epsilon-greedy action selection
// Revision     : 1.0
// ============================================================================
module q_agent_core
  import q_agent_pkg::*;
#(
  parameter int unsigned Q_W         = 16,
  parameter int unsigned ALPHA_SHIFT = 2,
  parameter int unsigned GAMMA_SHIFT = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  en,
  input  logic [5:0]            next_state,
  input  logic signed [Q_W-1:0] reward,
  input  logic                  terminal,
  input  logic [15:0]           epsilon,
  output logic [3:0]            next_action,
  output logic                  action_valid,
  output logic                  busy,
  input  logic [5:0]            dbg_state,
  input  logic [1:0]            dbg_action,
  output logic [Q_W-1:0]        dbg_q
);

  localparam int unsigned EW = Q_W + 2;
  localparam logic signed [EW-1:0] SAT_HI = {3'b000, {(Q_W-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_LO = {3'b111, {(Q_W-1){1'b0}}};

  fsm_e                  state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [4:0]            s_nxt_q, s_nxt_d;
  logic signed [Q_W-1:0] reward_q, reward_d;
  logic                  term_q, term_d;
  logic [15:0]           eps_q, eps_d;
  logic [1:0]            k_q, k_d;
  logic signed [Q_W-1:0] maxq_q, maxq_d;
  logic [1:0]            argmax_q, argmax_d;
  logic [4:0]            s_cur_q, s_cur_d;
  logic [1:0]            a_cur_q, a_cur_d;
  logic [1:0]            act_q, act_d;
  logic                  valid_q, valid_d;
  logic signed [Q_W-1:0] qtab_q [Q_ENTRIES];
  logic signed [Q_W-1:0] qtab_d [Q_ENTRIES];

  logic [15:0]           lfsr_val;
  logic signed [Q_W-1:0] q_scan, q_old, q_new;
  logic signed [EW-1:0]  max_x, rew_x, old_x, target, delta, sum;
  logic [1:0]            act_sel;
  logic                  unused_bits;

  q_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .lfsr  (lfsr_val)
  );

  // Update datapath: intermediates carry two guard bits so nothing wraps
  // before saturation.
  always_comb begin
    q_scan = qtab_q[{s_nxt_q, k_q}];
    q_old  = qtab_q[{s_cur_q, a_cur_q}];
    max_x  = {{2{maxq_q[Q_W-1]}}, maxq_q};
    rew_x  = {{2{reward_q[Q_W-1]}}, reward_q};
    old_x  = {{2{q_old[Q_W-1]}}, q_old};
    if (term_q) target = rew_x;
    else        target = rew_x + max_x - (max_x >>> GAMMA_SHIFT);
    delta  = target - old_x;
    sum    = old_x + (delta >>> ALPHA_SHIFT);
    if (sum > SAT_HI)      q_new = SAT_HI[Q_W-1:0];
    else if (sum < SAT_LO) q_new = SAT_LO[Q_W-1:0];
    else                   q_new = sum[Q_W-1:0];
    act_sel = (lfsr_val < eps_q) ? lfsr_val[1:0] : argmax_q;
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    s_nxt_d  = s_nxt_q;
    reward_d = reward_q;
    term_d   = term_q;
    eps_d    = eps_q;
    k_d      = k_q;
    maxq_d   = maxq_q;
    argmax_d = argmax_q;
    s_cur_d  = s_cur_q;
    a_cur_d  = a_cur_q;
    act_d    = act_q;
    valid_d  = 1'b0;
    qtab_d   = qtab_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start || en) begin
          mode_d   = start ? MODE_START : MODE_STEP;
          s_nxt_d  = next_state[4:0];
          reward_d = reward;
          term_d   = terminal;
          eps_d    = epsilon;
          k_d      = 2'd0;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // strict compare keeps the lowest index on ties
        if ((k_q == 2'd0) || (q_scan > maxq_q)) begin
          maxq_d   = q_scan;
          argmax_d = k_q;
        end
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = ST_UPD;
      end
      ST_UPD: begin
        if (mode_q == MODE_STEP) qtab_d[{s_cur_q, a_cur_q}] = q_new;
        state_d = ST_SEL;
      end
      ST_SEL: begin
        act_d   = act_sel;
        valid_d = 1'b1;
        s_cur_d = s_nxt_q;
        a_cur_d = act_sel;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_STEP;
      s_nxt_q  <= '0;
      reward_q <= '0;
      term_q   <= 1'b0;
      eps_q    <= '0;
      k_q      <= '0;
      maxq_q   <= '0;
      argmax_q <= ACT_UP;
      s_cur_q  <= '0;
      a_cur_q  <= ACT_UP;
      act_q    <= ACT_UP;
      valid_q  <= 1'b0;
      qtab_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      s_nxt_q  <= s_nxt_d;
      reward_q <= reward_d;
      term_q   <= term_d;
      eps_q    <= eps_d;
      k_q      <= k_d;
      maxq_q   <= maxq_d;
      argmax_q <= argmax_d;
      s_cur_q  <= s_cur_d;
      a_cur_q  <= a_cur_d;
      act_q    <= act_d;
      valid_q  <= valid_d;
      qtab_q   <= qtab_d;
    end
  end

  // state values 32..63 alias onto slots 0..31
  assign unused_bits  = ^{next_state[5], dbg_state[5]};
  assign dbg_q        = qtab_q[{dbg_state[4:0], dbg_action}];
  assign next_action  = {2'b00, act_q};
  assign action_valid = valid_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_q_agent_core.sv
`default_nettype none
// ============================================================================
// tb_q_agent_core : directed self-checking bench for q_agent_core
// Revision        : 1.0
// ============================================================================
module tb_q_agent_core;

  logic               clk = 1'b0;
  logic               rst_n, start, en, terminal;
  logic [5:0]         next_state, dbg_state;
  logic signed [15:0] reward;
  logic [15:0]        epsilon, dbg_q;
  logic [1:0]         dbg_action;
  logic [3:0]         next_action;
  logic               action_valid, busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] lfsr_m, lfsr_prev_m;

  q_agent_core dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .en           (en),
    .next_state   (next_state),
    .reward       (reward),
    .terminal     (terminal),
    .epsilon      (epsilon),
    .next_action  (next_action),
    .action_valid (action_valid),
    .busy         (busy),
    .dbg_state    (dbg_state),
    .dbg_action   (dbg_action),
    .dbg_q        (dbg_q)
  );

  always #5 clk = ~clk;

  // Reference LFSR: lfsr_prev_m holds the value the DUT saw before the last edge
  always @(posedge clk) begin
    lfsr_prev_m = lfsr_m;
    if (!rst_n) lfsr_m = 16'hACE1;
    else        lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic rdq(input logic [5:0] s, input logic [1:0] a,
                     output logic signed [15:0] v);
    dbg_state  = s;
    dbg_action = a;
    #1;
    v = dbg_q;
  endtask

  // Called at a negedge; returns cycles from accept edge to action_valid.
  task automatic req(input logic s, input logic e, input logic [5:0] ns,
                     input logic signed [15:0] r, input logic t,
                     input logic [15:0] eps, output int lat,
                     output logic [3:0] act, output logic [15:0] lfsr_used);
    start = s; en = e; next_state = ns; reward = r; terminal = t; epsilon = eps;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; en = 1'b0;
    lat = 0; act = 4'hF; lfsr_used = 16'h0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (action_valid) begin
        lat = i;
        act = next_action;
        lfsr_used = lfsr_prev_m;
      end
    end
  endtask

  task automatic count_nonzero(output int nz);
    logic signed [15:0] v;
    nz = 0;
    for (int s = 0; s < 32; s++)
      for (int a = 0; a < 4; a++) begin
        rdq(6'(s), 2'(a), v);
        if (v !== 16'sd0) nz++;
      end
  endtask

  initial begin
    int lat, nz, qm, pulses, first;
    logic [3:0] act;
    logic [15:0] lu;
    logic signed [15:0] v;

    rst_n = 1'b0; start = 1'b0; en = 1'b0; terminal = 1'b0;
    next_state = '0; reward = '0; epsilon = '0; dbg_state = '0; dbg_action = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", action_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_action", next_action, 0);
    rst_n = 1'b1;
    count_nonzero(nz);
    chk("rst_table_nonzero", nz, 0);

    // Episode start, then first step
    req(1, 0, 6'd1, 16'sd0, 0, 16'h0, lat, act, lu);
    chk("start_latency", lat, 6);
    chk("start_action", act, 0);
    req(0, 1, 6'd2, 16'sd100, 0, 16'h0, lat, act, lu);
    chk("step1_latency", lat, 6);
    chk("step1_action", act, 0);
    rdq(6'd1, 2'd0, v); chk("q_1_0", v, 25);

    // Walk the table to reach pair (3,1) with Q(2,2)=80
    req(0, 1, 6'd2, -16'sd400, 1, 16'h0, lat, act, lu);
    chk("A_action", act, 0);
    rdq(6'd2, 2'd0, v); chk("A_q_2_0", v, -100);
    req(0, 1, 6'd2, -16'sd400, 1, 16'h0, lat, act, lu);
    chk("B_action", act, 1);
    rdq(6'd2, 2'd0, v); chk("B_q_2_0", v, -175);
    req(0, 1, 6'd3, -16'sd400, 1, 16'h0, lat, act, lu);
    chk("C_action", act, 0);
    rdq(6'd2, 2'd1, v); chk("C_q_2_1", v, -100);
    req(1, 0, 6'd2, 16'sd0, 0, 16'h0, lat, act, lu);
    chk("D_start_action", act, 2);
    req(0, 1, 6'd3, 16'sd320, 1, 16'h0, lat, act, lu);
    chk("E_action", act, 0);
    rdq(6'd2, 2'd2, v); chk("E_q_2_2", v, 80);
    req(0, 1, 6'd3, -16'sd400, 1, 16'h0, lat, act, lu);
    chk("F_action", act, 0);
    rdq(6'd3, 2'd0, v); chk("F_q_3_0", v, -100);
    req(1, 0, 6'd3, 16'sd0, 0, 16'h0, lat, act, lu);
    chk("G_start_action", act, 1);
    req(0, 1, 6'd2, 16'sd0, 0, 16'h0, lat, act, lu);
    chk("H_action", act, 2);
    rdq(6'd3, 2'd1, v); chk("H_q_3_1", v, 17);
    rdq(6'd34, 2'd2, v); chk("alias_34_is_2", v, 80);

    // Terminal reward 32767 on pair (2,2), ten times
    qm = 80;
    for (int i = 0; i < 10; i++) begin
      req(0, 1, 6'd2, 16'sd32767, 1, 16'h0, lat, act, lu);
      qm = qm + ((32767 - qm) >>> 2);
      chk("term_action", act, 2);
      rdq(6'd2, 2'd2, v); chk("term_q_2_2", v, qm);
    end
    rdq(6'd2, 2'd2, v); chk("term_final", v, 30925);

    // Nonterminal with large maxQ drives the sum past +32767
    req(0, 1, 6'd2, 16'sd32767, 0, 16'h0, lat, act, lu);
    rdq(6'd2, 2'd2, v); chk("sat_first", v, 32767);
    req(0, 1, 6'd2, 16'sd32767, 0, 16'h0, lat, act, lu);
    rdq(6'd2, 2'd2, v); chk("sat_hold", v, 32767);
    chk("sat_action", act, 2);

    // Exploration: state 5 is all-zero so greedy would give 0
    for (int i = 0; i < 4; i++) begin
      req(1, 0, 6'd5, 16'sd0, 0, 16'hFFFF, lat, act, lu);
      chk("explore_action", act, (lu < 16'hFFFF) ? {2'b00, lu[1:0]} : 4'd0);
    end

    // en during SCAN must be ignored
    start = 1'b1; next_state = 6'd4; epsilon = 16'h0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("scan_busy", busy, 1);
    en = 1'b1; next_state = 6'd9; reward = 16'sd1000;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    pulses = 0; first = 0;
    for (int i = 3; i <= 16; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (action_valid) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    chk("ignore_pulses", pulses, 1);
    chk("ignore_latency", first, 6);
    chk("ignore_idle_busy", busy, 0);
    rdq(6'd3, 2'd1, v); chk("ignore_no_write", v, 17);

    // Reset asserted while in UPD
    en = 1'b1; next_state = 6'd3; reward = 16'sd400; terminal = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("upd_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("upd_rst_valid", action_valid, 0);
    chk("upd_rst_busy", busy, 0);
    chk("upd_rst_action", next_action, 0);
    rst_n = 1'b1;
    count_nonzero(nz);
    chk("upd_rst_table_nonzero", nz, 0);
    req(1, 0, 6'd1, 16'sd0, 0, 16'hFFFF, lat, act, lu);
    chk("post_rst_latency", lat, 6);
    chk("post_rst_explore", act, (lu < 16'hFFFF) ? {2'b00, lu[1:0]} : 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
